ddr3_wb_port_arbiter: RTL and testbench

- Multi-port Wishbone (pipelined) front end for the DDR3 top level.
- Merges NUM_PORTS independent masters onto the single controller Wishbone port using round-robin arbitration.
- Tracks outstanding requests in order and routes each controller ack and its read data back to the issuing port.
- Supports per-port bus abort without ever aborting the shared controller bus.

---
 rtl/ddr3_pkg.sv | 19 +
 rtl/ddr3_wb_port_arbiter_if.sv | 47 ++++
 rtl/ddr3_wb_pending_fifo.sv | 65 ++++++
 rtl/ddr3_wb_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_ddr3_wb_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_pkg.sv
// Shared types for the DDR3 multi-port Wishbone front end.
// No logic here; the pending-entry layout and port-index sizing live in this package.
package ddr3_pkg;

    localparam int MAX_ID_BITS = 3;
    localparam int MAX_IDS     = 1 << MAX_ID_BITS;

    function automatic int calc_id_bits(input int num_ports);
        return (num_ports <= 2) ? 1 : $clog2(num_ports);
    endfunction

    // One outstanding downstream request: issuing port, its tag, and whether its ack is dropped
    typedef struct packed {
        logic [MAX_ID_BITS-1:0] id;
        logic                   aux;
        logic                   discard;
    } pend_entry_t;

endpackage

// File: rtl/ddr3_wb_port_arbiter_if.sv
// Bundle of the per-port upstream Wishbone buses and the single controller-side Wishbone bus.
// The arbiter connects through the slave modport; the master modport is the environment's view.
interface ddr3_wb_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 512,
    parameter int SEL_BITS  = DATA_BITS / 8
);
    logic [NUM_PORTS-1:0]           i_wb_cyc;
    logic [NUM_PORTS-1:0]           i_wb_stb;
    logic [NUM_PORTS-1:0]           i_wb_we;
    logic [NUM_PORTS*ADDR_BITS-1:0] i_wb_addr;
    logic [NUM_PORTS*DATA_BITS-1:0] i_wb_data;
    logic [NUM_PORTS*SEL_BITS-1:0]  i_wb_sel;
    logic [NUM_PORTS-1:0]           i_aux;
    logic [NUM_PORTS-1:0]           o_wb_stall;
    logic [NUM_PORTS-1:0]           o_wb_ack;
    logic [DATA_BITS-1:0]           o_wb_data;
    logic                           o_aux;
    logic                           o_dn_cyc;
    logic                           o_dn_stb;
    logic                           o_dn_we;
    logic [ADDR_BITS-1:0]           o_dn_addr;
    logic [DATA_BITS-1:0]           o_dn_data;
    logic [SEL_BITS-1:0]            o_dn_sel;
    logic                           i_dn_stall;
    logic                           i_dn_ack;
    logic [DATA_BITS-1:0]           i_dn_data;
    logic                           o_err_unexpected_ack;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_aux,
        input  i_dn_stall, i_dn_ack, i_dn_data,
        output o_wb_stall, o_wb_ack, o_wb_data, o_aux,
        output o_dn_cyc, o_dn_stb, o_dn_we, o_dn_addr, o_dn_data, o_dn_sel,
        output o_err_unexpected_ack
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_aux,
        output i_dn_stall, i_dn_ack, i_dn_data,
        input  o_wb_stall, o_wb_ack, o_wb_data, o_aux,
        input  o_dn_cyc, o_dn_stb, o_dn_we, o_dn_addr, o_dn_data, o_dn_sel,
        input  o_err_unexpected_ack
    );

endinterface

// File: rtl/ddr3_wb_pending_fifo.sv
// In-order tracker of outstanding requests with per-entry discard bits set by an id broadcast.
// Registered pointers; full/empty from registered state; caller must not push when full.
module ddr3_wb_pending_fifo
    import ddr3_pkg::*;
#(
    parameter int MAX_PENDING = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  pend_entry_t        push_entry,
    input  logic               pop,
    input  logic [MAX_IDS-1:0] mark_ids,
    output logic               full,
    output logic               empty,
    output pend_entry_t        head,
    output logic               head_discard
);
    localparam int AW = $clog2(MAX_PENDING);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pend_entry_t mem_q [MAX_PENDING];
    pend_entry_t mem_d [MAX_PENDING];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    // A mark arriving in the same cycle as the pop must still suppress the head
    assign head_discard = head.discard | mark_ids[head.id];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (mark_ids[mem_q[i].id]) begin
                mem_d[i].discard = 1'b1;
            end
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ddr3_wb_port_arbiter.sv
// Round-robin merge of NUM_PORTS Wishbone masters onto one controller port; acks returned 1 cycle after i_dn_ack.
// Backpressure: ungranted ports, downstream stall and a full pending tracker all stall the upstream port.
module ddr3_wb_port_arbiter
    import ddr3_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_BITS   = 24,
    parameter int DATA_BITS   = 512,
    parameter int SEL_BITS    = DATA_BITS / 8,
    parameter int MAX_PENDING = 16
) (
    input  logic                   i_controller_clk,
    input  logic                   i_rst,
    ddr3_wb_port_arbiter_if.slave  bus
);
    localparam int ID_BITS = calc_id_bits(NUM_PORTS);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant_oh;
    logic                 any_req;
    int                   gnt_idx;
    int                   nxt_idx;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 pop;
    logic                 push_aux;
    pend_entry_t          push_entry;
    pend_entry_t          head;
    logic                 head_discard;
    logic [MAX_IDS-1:0]   mark_ids;

    logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] cyc_q, cyc_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 aux_q, aux_d;
    logic                 err_q, err_d;

    assign req     = bus.i_wb_cyc & bus.i_wb_stb;
    assign any_req = |req;

    // Scan offsets from the far end so the port nearest rr_ptr wins
    always_comb begin
        gnt_idx = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            int k;
            k = int'(rr_ptr_q) + i;
            if (k >= NUM_PORTS) begin
                k = k - NUM_PORTS;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (k == p && req[p]) begin
                    gnt_idx = p;
                end
            end
        end
        grant_oh = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant_oh[p] = any_req && (gnt_idx == p);
        end
    end

    always_comb begin
        bus.o_dn_we   = 1'b0;
        bus.o_dn_addr = '0;
        bus.o_dn_data = '0;
        bus.o_dn_sel  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_oh[p]) begin
                bus.o_dn_we   = bus.i_wb_we[p];
                bus.o_dn_addr = bus.i_wb_addr[p*ADDR_BITS +: ADDR_BITS];
                bus.o_dn_data = bus.i_wb_data[p*DATA_BITS +: DATA_BITS];
                bus.o_dn_sel  = bus.i_wb_sel[p*SEL_BITS +: SEL_BITS];
            end
        end
    end

    assign bus.o_dn_stb   = any_req & ~fifo_full;
    assign bus.o_dn_cyc   = (|bus.i_wb_cyc) | ~fifo_empty;
    assign bus.o_wb_stall = ~(grant_oh & {NUM_PORTS{~bus.i_dn_stall & ~fifo_full}});
    assign accept         = bus.o_dn_stb & ~bus.i_dn_stall;
    assign pop            = bus.i_dn_ack & ~fifo_empty;
    assign push_aux       = |(grant_oh & bus.i_aux);

    always_comb begin
        push_entry         = '0;
        push_entry.id      = MAX_ID_BITS'(gnt_idx);
        push_entry.aux     = push_aux;
        push_entry.discard = 1'b0;
        mark_ids                  = '0;
        mark_ids[NUM_PORTS-1:0]   = cyc_q & ~bus.i_wb_cyc;
    end

    always_comb begin
        nxt_idx  = (gnt_idx + 1 >= NUM_PORTS) ? 0 : gnt_idx + 1;
        rr_ptr_d = accept ? ID_BITS'(nxt_idx) : rr_ptr_q;
        cyc_d    = bus.i_wb_cyc;
        err_d    = err_q | (bus.i_dn_ack & fifo_empty);
        ack_d    = '0;
        data_d   = data_q;
        aux_d    = aux_q;
        if (pop && !head_discard) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (head.id == MAX_ID_BITS'(p)) begin
                    ack_d[p] = 1'b1;
                end
            end
            data_d = bus.i_dn_data;
            aux_d  = head.aux;
        end
    end

    always_ff @(posedge i_controller_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            cyc_q    <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            aux_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cyc_q    <= cyc_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            aux_q    <= aux_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_wb_ack             = ack_q;
    assign bus.o_wb_data            = data_q;
    assign bus.o_aux                = aux_q;
    assign bus.o_err_unexpected_ack = err_q;

    ddr3_wb_pending_fifo #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending (
        .clk          (i_controller_clk),
        .rst          (i_rst),
        .push         (accept),
        .push_entry   (push_entry),
        .pop          (pop),
        .mark_ids     (mark_ids),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .head         (head),
        .head_discard (head_discard)
    );

endmodule

// File: tb/tb_ddr3_wb_port_arbiter.sv
// Directed bench for the multi-port Wishbone arbiter: arbitration, ack routing, full tracker, abort, error flag.
module tb_ddr3_wb_port_arbiter;

    localparam int NP = 4;
    localparam int AB = 24;
    localparam int DB = 512;
    localparam int SB = DB / 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ddr3_wb_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .SEL_BITS(SB)) bus ();

    ddr3_wb_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .SEL_BITS(SB), .MAX_PENDING(16)
    ) dut (
        .i_controller_clk (clk),
        .i_rst            (rst),
        .bus              (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic cyc, input logic stb, input logic we,
                            input logic [AB-1:0] addr, input logic aux);
        bus.i_wb_cyc[p]           = cyc;
        bus.i_wb_stb[p]           = stb;
        bus.i_wb_we[p]            = we;
        bus.i_wb_addr[p*AB +: AB] = addr;
        bus.i_wb_data[p*DB +: DB] = {16{8'h5A, addr}};
        bus.i_wb_sel[p*SB +: SB]  = '1;
        bus.i_aux[p]              = aux;
    endtask

    task automatic idle_all();
        bus.i_wb_cyc   = '0;
        bus.i_wb_stb   = '0;
        bus.i_wb_we    = '0;
        bus.i_wb_addr  = '0;
        bus.i_wb_data  = '0;
        bus.i_wb_sel   = '0;
        bus.i_aux      = '0;
        bus.i_dn_stall = 1'b0;
        bus.i_dn_ack   = 1'b0;
        bus.i_dn_data  = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.o_wb_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", bus.o_wb_ack); end
        checks++; if (bus.o_wb_data !== '0) begin errors++; $display("FAIL reset_data: got nonzero want 0"); end
        checks++; if (bus.o_aux !== 1'b0) begin errors++; $display("FAIL reset_aux: got %b want 0", bus.o_aux); end
        checks++; if (bus.o_err_unexpected_ack !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.o_err_unexpected_ack); end
        checks++; if (bus.o_dn_cyc !== 1'b0 || bus.o_dn_stb !== 1'b0) begin errors++; $display("FAIL reset_dn: cyc %b stb %b want 0 0", bus.o_dn_cyc, bus.o_dn_stb); end
        checks++; if (bus.o_wb_stall !== 4'b1111) begin errors++; $display("FAIL reset_stall: got %b want 1111", bus.o_wb_stall); end
    endtask

    task automatic test_single_write();
        logic [DB-1:0] d;
        d = {16{32'hCAFE_0001}};
        set_port(0, 1'b1, 1'b1, 1'b1, 24'h000100, 1'b0);
        #1;
        checks++; if (bus.o_dn_stb !== 1'b1 || bus.o_dn_we !== 1'b1) begin errors++; $display("FAIL single_stb: stb %b we %b want 1 1", bus.o_dn_stb, bus.o_dn_we); end
        checks++; if (bus.o_dn_addr !== 24'h000100) begin errors++; $display("FAIL single_addr: got %h want 000100", bus.o_dn_addr); end
        checks++; if (bus.o_wb_stall !== 4'b1110) begin errors++; $display("FAIL single_stall: got %b want 1110", bus.o_wb_stall); end
        step();
        bus.i_wb_stb[0] = 1'b0;
        #1;
        checks++; if (bus.o_dn_stb !== 1'b0 || bus.o_dn_cyc !== 1'b1) begin errors++; $display("FAIL single_after: stb %b cyc %b want 0 1", bus.o_dn_stb, bus.o_dn_cyc); end
        repeat (4) step();
        bus.i_dn_ack  = 1'b1;
        bus.i_dn_data = d;
        #1;
        checks++; if (bus.o_wb_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_early: got %b want 0000", bus.o_wb_ack); end
        step();
        bus.i_dn_ack = 1'b0;
        checks++; if (bus.o_wb_ack !== 4'b0001 || bus.o_wb_data !== d) begin errors++; $display("FAIL single_ack: got %b want 0001 (data match %b)", bus.o_wb_ack, bus.o_wb_data === d); end
        step();
        checks++; if (bus.o_wb_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_len: got %b want 0000", bus.o_wb_ack); end
        bus.i_wb_cyc[0] = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int cnt [NP];
        int consec [NP];
        int maxc;
        logic [3:0] exp_g;
        logic [DB-1:0] d;
        rst = 1'b1;
        step();
        rst = 1'b0;
        maxc = 0;
        for (int p = 0; p < NP; p++) begin
            set_port(p, 1'b1, 1'b1, 1'b0, AB'(24'h001000 * (p + 1)), 1'b0);
            cnt[p] = 0;
            consec[p] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = 4'(1 << (k % 4));
            checks++; if (bus.o_wb_stall !== ~exp_g) begin errors++; $display("FAIL rr_grant[%0d]: stall %b want %b", k, bus.o_wb_stall, ~exp_g); end
            checks++; if (bus.o_dn_addr !== AB'(24'h001000 * ((k % 4) + 1))) begin errors++; $display("FAIL rr_addr[%0d]: got %h", k, bus.o_dn_addr); end
            for (int p = 0; p < NP; p++) begin
                if (!bus.o_wb_stall[p]) begin cnt[p]++; consec[p] = 0; end
                else begin consec[p]++; if (consec[p] > maxc) maxc = consec[p]; end
            end
            step();
        end
        for (int p = 0; p < NP; p++) begin
            checks++; if (cnt[p] != 2) begin errors++; $display("FAIL rr_count[%0d]: got %0d want 2", p, cnt[p]); end
        end
        checks++; if (maxc > 3) begin errors++; $display("FAIL rr_starve: max stall run %0d want <=3", maxc); end
        bus.i_wb_stb = '0;
        for (int k = 0; k < 8; k++) begin
            d = {16{32'(k)}};
            bus.i_dn_ack  = 1'b1;
            bus.i_dn_data = d;
            step();
            exp_g = 4'(1 << (k % 4));
            checks++; if (bus.o_wb_ack !== exp_g || bus.o_wb_data !== d) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.o_wb_ack, exp_g); end
        end
        bus.i_dn_ack = 1'b0;
        step();
        checks++; if (bus.o_wb_ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_end: got %b want 0000", bus.o_wb_ack); end
        bus.i_wb_cyc = '0;
        #1;
        checks++; if (bus.o_dn_cyc !== 1'b0) begin errors++; $display("FAIL rr_cyc_end: got %b want 0", bus.o_dn_cyc); end
        step();
    endtask

    task automatic test_fifo_full();
        int acc;
        int acks;
        acc = 0;
        set_port(1, 1'b1, 1'b1, 1'b0, 24'h00ABCD, 1'b0);
        for (int k = 0; k < 16; k++) begin
            #1;
            if (!bus.o_wb_stall[1] && bus.o_dn_stb) acc++;
            step();
        end
        checks++; if (acc != 16) begin errors++; $display("FAIL full_accepts: got %0d want 16", acc); end
        #1;
        checks++; if (bus.o_wb_stall[1] !== 1'b1 || bus.o_dn_stb !== 1'b0) begin errors++; $display("FAIL full_17th: stall %b stb %b want 1 0", bus.o_wb_stall[1], bus.o_dn_stb); end
        bus.i_dn_ack  = 1'b1;
        bus.i_dn_data = {16{32'h1111_2222}};
        #1;
        checks++; if (bus.o_wb_stall[1] !== 1'b1) begin errors++; $display("FAIL full_pop_same: stall %b want 1", bus.o_wb_stall[1]); end
        step();
        bus.i_dn_ack = 1'b0;
        #1;
        checks++; if (bus.o_wb_ack !== 4'b0010) begin errors++; $display("FAIL full_ack: got %b want 0010", bus.o_wb_ack); end
        checks++; if (bus.o_wb_stall[1] !== 1'b0 || bus.o_dn_stb !== 1'b1) begin errors++; $display("FAIL full_resume: stall %b stb %b want 0 1", bus.o_wb_stall[1], bus.o_dn_stb); end
        step();
        checks++; if (bus.o_wb_stall[1] !== 1'b1) begin errors++; $display("FAIL full_again: stall %b want 1", bus.o_wb_stall[1]); end
        bus.i_wb_stb[1] = 1'b0;
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            bus.i_dn_ack = 1'b1;
            step();
            if (bus.o_wb_ack === 4'b0010) acks++;
        end
        bus.i_dn_ack = 1'b0;
        checks++; if (acks != 16) begin errors++; $display("FAIL full_drain: got %0d acks want 16", acks); end
        bus.i_wb_cyc[1] = 1'b0;
        step();
        checks++; if (bus.o_dn_cyc !== 1'b0 || bus.o_wb_ack !== 4'b0000) begin errors++; $display("FAIL full_empty: cyc %b ack %b want 0 0000", bus.o_dn_cyc, bus.o_wb_ack); end
    endtask

    task automatic test_ordering();
        int   seq  [4] = '{2, 0, 2, 2};
        logic auxv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [DB-1:0] d;
        logic [3:0] exp_a;
        bus.i_wb_cyc[0] = 1'b1;
        bus.i_wb_cyc[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_wb_stb = '0;
            set_port(seq[k], 1'b1, 1'b1, 1'b0, AB'(24'h000200 + k), auxv[k]);
            #1;
            checks++; if (bus.o_dn_stb !== 1'b1 || bus.o_dn_addr !== AB'(24'h000200 + k)) begin errors++; $display("FAIL ord_issue[%0d]: stb %b addr %h", k, bus.o_dn_stb, bus.o_dn_addr); end
            step();
        end
        bus.i_wb_stb = '0;
        for (int k = 0; k < 4; k++) begin
            d = {16{32'hD000_0000 + 32'(k)}};
            bus.i_dn_ack  = 1'b1;
            bus.i_dn_data = d;
            step();
            exp_a = 4'(1 << seq[k]);
            checks++; if (bus.o_wb_ack !== exp_a || bus.o_aux !== auxv[k] || bus.o_wb_data !== d) begin
                errors++; $display("FAIL ord_ack[%0d]: ack %b aux %b want %b %b (data match %b)", k, bus.o_wb_ack, bus.o_aux, exp_a, auxv[k], bus.o_wb_data === d);
            end
        end
        bus.i_dn_ack = 1'b0;
        bus.i_wb_cyc = '0;
        step();
    endtask

    task automatic test_abort();
        logic [3:0] got [3];
        logic       cyc_ok;
        set_port(3, 1'b1, 1'b1, 1'b0, 24'h000300, 1'b0);
        step();
        step();
        set_port(3, 1'b0, 1'b0, 1'b0, 24'h000300, 1'b0);
        #1;
        checks++; if (bus.o_dn_cyc !== 1'b1) begin errors++; $display("FAIL abort_cyc_hold: got %b want 1", bus.o_dn_cyc); end
        step();
        set_port(1, 1'b1, 1'b1, 1'b0, 24'h000310, 1'b1);
        step();
        bus.i_wb_stb[1] = 1'b0;
        cyc_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_dn_ack  = 1'b1;
            bus.i_dn_data = {16{32'hAB00_0000 + 32'(k)}};
            #1;
            if (bus.o_dn_cyc !== 1'b1) cyc_ok = 1'b0;
            step();
            got[k] = bus.o_wb_ack;
        end
        bus.i_dn_ack = 1'b0;
        checks++; if (got[0] !== 4'b0000 || got[1] !== 4'b0000) begin errors++; $display("FAIL abort_discard: got %b %b want 0000 0000", got[0], got[1]); end
        checks++; if (got[2] !== 4'b0010 || bus.o_aux !== 1'b1) begin errors++; $display("FAIL abort_port1: ack %b aux %b want 0010 1", got[2], bus.o_aux); end
        checks++; if (!cyc_ok) begin errors++; $display("FAIL abort_cyc: dn_cyc dropped while acks owed, want held"); end
        bus.i_wb_cyc[1] = 1'b0;
        step();
        // Abort coinciding with the pop of that port's head
        set_port(0, 1'b1, 1'b1, 1'b0, 24'h000320, 1'b0);
        step();
        bus.i_wb_stb[0] = 1'b0;
        step();
        bus.i_wb_cyc[0] = 1'b0;
        bus.i_dn_ack    = 1'b1;
        step();
        bus.i_dn_ack = 1'b0;
        checks++; if (bus.o_wb_ack !== 4'b0000 || bus.o_err_unexpected_ack !== 1'b0) begin errors++; $display("FAIL abort_same_cycle: ack %b err %b want 0000 0", bus.o_wb_ack, bus.o_err_unexpected_ack); end
        checks++; if (bus.o_dn_cyc !== 1'b0) begin errors++; $display("FAIL abort_drained: dn_cyc %b want 0", bus.o_dn_cyc); end
    endtask

    task automatic test_unexpected_ack();
        bus.i_dn_ack = 1'b1;
        step();
        bus.i_dn_ack = 1'b0;
        checks++; if (bus.o_wb_ack !== 4'b0000 || bus.o_err_unexpected_ack !== 1'b1) begin errors++; $display("FAIL unexp_set: ack %b err %b want 0000 1", bus.o_wb_ack, bus.o_err_unexpected_ack); end
        step();
        step();
        checks++; if (bus.o_err_unexpected_ack !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b want 1", bus.o_err_unexpected_ack); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.o_err_unexpected_ack !== 1'b0 || bus.o_dn_cyc !== 1'b0) begin errors++; $display("FAIL unexp_clear: err %b cyc %b want 0 0", bus.o_err_unexpected_ack, bus.o_dn_cyc); end
        set_port(0, 1'b1, 1'b1, 1'b0, 24'h000400, 1'b0);
        set_port(2, 1'b1, 1'b1, 1'b0, 24'h000420, 1'b0);
        #1;
        checks++; if (bus.o_wb_stall !== 4'b1110 || bus.o_dn_addr !== 24'h000400) begin errors++; $display("FAIL unexp_rr_reset: stall %b addr %h want 1110 000400", bus.o_wb_stall, bus.o_dn_addr); end
        idle_all();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_single_write();
        test_round_robin();
        test_fifo_full();
        test_ordering();
        test_abort();
        test_unexpected_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
